// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared state encodings, ALU opcodes and helpers for the CPU op sequencer
package cpu_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_B    = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_SHOW      = 3'd4
  } seq_state_e;
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } alu_op_e;
  function automatic logic is_busy(seq_state_e s);
    return (s == S_ISSUE) || (s == S_WAIT_DONE);
  endfunction
endpackage

// File: rtl/cpu_op_sequencer_if.sv
// cpu_op_sequencer_if: sequencer <-> datapath handshake bundle
//  master (sequencer): drives dp_enable, dp_opcode, dp_a, dp_b; receives dp_done, dp_result
//  slave  (datapath):  the reverse
interface cpu_op_sequencer_if
  import cpu_seq_pkg::*;
#(
  parameter int DATA_W = 4
) ();
  logic              dp_enable;
  alu_op_e           dp_opcode;
  logic [DATA_W-1:0] dp_a;
  logic [DATA_W-1:0] dp_b;
  logic              dp_done;
  logic [DATA_W:0]   dp_result;
  modport master (output dp_enable, dp_opcode, dp_a, dp_b, input dp_done, dp_result);
  modport slave  (input dp_enable, dp_opcode, dp_a, dp_b, output dp_done, dp_result);
endinterface

// File: rtl/cpu_op_sequencer_sw_sync_edge.sv
// sw_sync_edge: synchronizes the raw push-button and emits a one-cycle press per high level
//  clock, reset_n : rising-edge clock, synchronous active-low reset
//  raw_i          : asynchronous button input
//  press_o        : registered one-cycle press pulse
//  SEQ_DEBOUNCE_EN: when defined, a press needs DEBOUNCE_CYC consecutive high samples
module sw_sync_edge #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_i,
  output logic press_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl;
  logic                   press_q;
  assign lvl     = sync_q[SYNC_STAGES-1];
  assign press_o = press_q;
  always_ff @(posedge clock) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
  end
`ifdef SEQ_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  logic [DB_W-1:0] db_q, db_d;
  // count saturates at DEBOUNCE_CYC so a long hold yields one press only
  assign db_d = !lvl ? '0 : (db_q == DB_W'(DEBOUNCE_CYC)) ? db_q : db_q + 1'b1;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      db_q    <= '0;
      press_q <= 1'b0;
    end else begin
      db_q    <= db_d;
      press_q <= lvl && (db_q == DB_W'(DEBOUNCE_CYC - 1));
    end
  end
`else
  logic prev_q;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      prev_q  <= lvl;
      press_q <= lvl & ~prev_q;
    end
  end
`endif
endmodule

// File: rtl/cpu_op_sequencer.sv
// cpu_op_sequencer: captures two switch operands on button presses, starts the datapath, waits for done/timeout
//  clock, reset_n  : rising-edge clock, synchronous active-low reset
//  sw, op_sel      : operand switches and ALU function code
//  operation       : raw push-button request
//  dp              : datapath handshake (master modport)
//  result, result_valid, busy, err : display/status outputs
//  SEQ_DEBOUNCE_EN : enables press debounce inside sw_sync_edge
module cpu_op_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [DATA_W-1:0]   sw,
  input  logic                operation,
  input  logic [1:0]          op_sel,
  cpu_op_sequencer_if.master  dp,
  output logic [DATA_W:0]     result,
  output logic                result_valid,
  output logic                busy,
  output logic                err
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  alu_op_e           opc_q, opc_d;
  logic [DATA_W:0]   res_q, res_d;
  logic              rv_q, rv_d, err_q, err_d;
  logic              press;
  logic              expired;
  sw_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .raw_i  (operation),
    .press_o(press)
  );
  assign expired      = cnt_q == CNT_W'(TIMEOUT_CYC - 1);
  assign dp.dp_enable = state_q == S_ISSUE;
  assign dp.dp_opcode = opc_q;
  assign dp.dp_a      = a_q;
  assign dp.dp_b      = b_q;
  assign result       = res_q;
  assign result_valid = rv_q;
  assign busy         = is_busy(state_q);
  assign err          = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    opc_d   = opc_q;
    res_d   = res_q;
    rv_d    = rv_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (press) begin
        a_d     = sw;
        err_d   = 1'b0;
        state_d = S_WAIT_B;
      end
      S_WAIT_B: if (press) begin
        b_d     = sw;
        opc_d   = alu_op_e'(op_sel);
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // done in the expiry cycle takes priority over the timeout
        if (dp.dp_done) begin
          res_d   = dp.dp_result;
          rv_d    = 1'b1;
          state_d = S_SHOW;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHOW: if (press) begin
        rv_d    = 1'b0;
        a_d     = sw;
        state_d = S_WAIT_B;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      opc_q   <= OP_ADD;
      res_q   <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opc_q   <= opc_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
    end
  end
endmodule
